alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters (Req0: main datapath issue port; Req1: auxiliary/debug port).
- Arbitrates round-robin, registers the winning operands, and holds them stable on the ALU inputs for a fixed number of cycles (longer for multiply).
- Captures the result and returns it through a valid/ready response channel tagged with the requester ID.
- Sits between the requesters and the ALU; the ALU instance is external and wired to the Alu* ports.

---
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Operands are held on the ALU for 1 cycle (MUL_LAT for MUL); the result returns on a tagged valid/ready channel.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Req0Valid,
  output logic             Req0Ready,
  input  logic [WIDTH-1:0] Req0A,
  input  logic [WIDTH-1:0] Req0B,
  input  logic [2:0]       Req0Op,
  input  logic             Req1Valid,
  output logic             Req1Ready,
  input  logic [WIDTH-1:0] Req1A,
  input  logic [WIDTH-1:0] Req1B,
  input  logic [2:0]       Req1Op,
  output logic             RspValid,
  input  logic             RspReady,
  output logic             RspId,
  output logic [WIDTH-1:0] RspResult,
  output logic             RspZero,
  output logic             RspErr,
  output logic [WIDTH-1:0] AluSrcA,
  output logic [WIDTH-1:0] AluSrcB,
  output logic [2:0]       AluControl,
  input  logic [WIDTH-1:0] AluResult
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [2:0] OP_MUL = 3'b101;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] src_a_q, src_a_d;
  logic [WIDTH-1:0] src_b_q, src_b_d;
  logic [2:0]       ctl_q, ctl_d;
  logic             id_q, id_d;
  logic             err_q, err_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_op;
  logic             op_legal;

  always_comb begin
    grant    = (Req0Valid && Req1Valid) ? ~last_grant_q : Req1Valid;
    accept   = (state_q == IDLE) && (grant ? Req1Valid : Req0Valid);
    req_a    = grant ? Req1A  : Req0A;
    req_b    = grant ? Req1B  : Req0B;
    req_op   = grant ? Req1Op : Req0Op;
    op_legal = (req_op != 3'b011) && (req_op != 3'b111);
  end

  assign Req0Ready = accept && !grant;
  assign Req1Ready = accept && grant;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    src_a_d      = src_a_q;
    src_b_d      = src_b_q;
    ctl_d        = ctl_q;
    id_d         = id_q;
    err_d        = err_q;
    rsp_vld_d    = rsp_vld_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d         = grant;
          last_grant_d = grant;
          err_d        = !op_legal;
          state_d      = EXEC;
          // Illegal ops spend one EXEC cycle with the ALU untouched, so every
          // non-MUL op returns with the same latency.
          if (op_legal) begin
            src_a_d = req_a;
            src_b_d = req_b;
            ctl_d   = req_op;
            cnt_d   = (req_op == OP_MUL) ? 4'(MUL_LAT) : 4'd1;
          end else begin
            cnt_d = 4'd1;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_vld_d    = 1'b1;
          rsp_id_d     = id_q;
          rsp_err_d    = err_q;
          rsp_result_d = err_q ? '0 : AluResult;
          rsp_zero_d   = !err_q && (AluResult == '0);
          state_d      = RESP;
        end
      end
      RESP: begin
        if (RspReady) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      ctl_q        <= '0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      rsp_vld_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      ctl_q        <= ctl_d;
      id_q         <= id_d;
      err_q        <= err_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign AluSrcA    = src_a_q;
  assign AluSrcB    = src_b_q;
  assign AluControl = ctl_q;
  assign RspValid   = rsp_vld_q;
  assign RspId      = rsp_id_q;
  assign RspResult  = rsp_result_q;
  assign RspZero    = rsp_zero_q;
  assign RspErr     = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic, checked by a
// reference model and response scoreboard running in a separate monitor process.
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int ML = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         v0, v1, r0, r1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [2:0]   op0, op1;
  logic         rsp_rdy, rsp_vld, rsp_id, rsp_zero, rsp_err;
  logic [W-1:0] rsp_res, alu_a, alu_b, alu_res;
  logic [2:0]   alu_ctl;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .Req0Valid(v0), .Req0Ready(r0), .Req0A(a0), .Req0B(b0), .Req0Op(op0),
    .Req1Valid(v1), .Req1Ready(r1), .Req1A(a1), .Req1B(b1), .Req1Op(op1),
    .RspValid(rsp_vld), .RspReady(rsp_rdy), .RspId(rsp_id), .RspResult(rsp_res),
    .RspZero(rsp_zero), .RspErr(rsp_err),
    .AluSrcA(alu_a), .AluSrcB(alu_b), .AluControl(alu_ctl), .AluResult(alu_res)
  );

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a - b;
      3'b101:  return a * b;
      3'b110:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // External ALU model
  assign alu_res = ref_alu(alu_ctl, alu_a, alu_b);

  typedef struct {
    logic         id;
    logic [W-1:0] res;
    logic         zero;
    logic         err;
    int           due;
  } exp_t;

  exp_t         sb[$];
  exp_t         cur;
  exp_t         e;
  bit           have_cur = 0;
  bit           busy = 0;
  logic         last_g = 1'b1;
  logic         g;
  logic [2:0]   m_op;
  logic [W-1:0] m_a, m_b;
  logic [W-1:0] ea = '0, eb = '0;
  logic [2:0]   ec = '0;
  int           cyc = 0;
  bit           acc0 = 0, acc1 = 0;
  int           n_cmp = 0, n_bad = 0;
  int           tmo_cnt = 0, tmo_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      chk("rst_rsp_vld", 64'(rsp_vld), 64'(0));
      chk("rst_rsp_id", 64'(rsp_id), 64'(0));
      chk("rst_rsp_res", 64'(rsp_res), 64'(0));
      chk("rst_rsp_zero", 64'(rsp_zero), 64'(0));
      chk("rst_rsp_err", 64'(rsp_err), 64'(0));
      chk("rst_alu_a", 64'(alu_a), 64'(0));
      chk("rst_alu_b", 64'(alu_b), 64'(0));
      chk("rst_alu_ctl", 64'(alu_ctl), 64'(0));
      chk("rst_rdy0", 64'(r0), 64'(0));
      chk("rst_rdy1", 64'(r1), 64'(0));
      sb.delete();
      have_cur = 0; busy = 0; last_g = 1'b1;
      ea = '0; eb = '0; ec = '0; acc0 = 0; acc1 = 0;
    end else begin
      cyc++;
      acc0 = 0; acc1 = 0;
      if (tmo_cnt != tmo_seen) begin
        chk("wait_bound", 64'(tmo_cnt), 64'(tmo_seen));
        tmo_seen = tmo_cnt;
      end
      chk("alu_src_a", 64'(alu_a), 64'(ea));
      chk("alu_src_b", 64'(alu_b), 64'(eb));
      chk("alu_ctl", 64'(alu_ctl), 64'(ec));
      if (busy) begin
        chk("busy_rdy0", 64'(r0), 64'(0));
        chk("busy_rdy1", 64'(r1), 64'(0));
      end else begin
        g = (v0 && v1) ? ~last_g : v1;
        chk("grant_rdy0", 64'(r0), 64'(v0 && !g));
        chk("grant_rdy1", 64'(r1), 64'(v1 && g));
        if (v0 || v1) begin
          m_op   = g ? op1 : op0;
          m_a    = g ? a1 : a0;
          m_b    = g ? b1 : b0;
          e.id   = g;
          e.err  = (m_op == 3'b011) || (m_op == 3'b111);
          e.res  = e.err ? '0 : ref_alu(m_op, m_a, m_b);
          e.zero = !e.err && (e.res == '0);
          e.due  = cyc + 1 + ((m_op == 3'b101) ? ML : 1);
          sb.push_back(e);
          busy = 1; last_g = g; acc0 = !g; acc1 = g;
          if (!e.err) begin
            ea = m_a; eb = m_b; ec = m_op;
          end
        end
      end
      if (rsp_vld) begin
        if (!have_cur) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_vld), 64'(0));
          end else begin
            cur = sb.pop_front();
            have_cur = 1;
            chk("rsp_latency", 64'(cyc), 64'(cur.due));
            chk("rsp_id", 64'(rsp_id), 64'(cur.id));
            chk("rsp_result", 64'(rsp_res), 64'(cur.res));
            chk("rsp_zero", 64'(rsp_zero), 64'(cur.zero));
            chk("rsp_err", 64'(rsp_err), 64'(cur.err));
          end
        end else begin
          chk("hold_id", 64'(rsp_id), 64'(cur.id));
          chk("hold_result", 64'(rsp_res), 64'(cur.res));
          chk("hold_zero", 64'(rsp_zero), 64'(cur.zero));
          chk("hold_err", 64'(rsp_err), 64'(cur.err));
        end
        if (have_cur && rsp_rdy) begin
          have_cur = 0;
          busy = 0;
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        chk("rsp_timeout", 64'(cyc), 64'(sb[0].due));
        void'(sb.pop_front());
        busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int id);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!((id == 1) ? acc1 : acc0) && n < 60);
    if (n >= 60) tmo_cnt++;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || have_cur) && n < 80) begin
      tick();
      n++;
    end
    if (n >= 80) tmo_cnt++;
    tick();
  endtask

  function automatic logic [W-1:0] rnd();
    return ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 1'b1;
    v0 = 0; v1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    op0 = '0; op1 = '0; rsp_rdy = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // ADD 5+7 from requester 0
    v0 = 1; a0 = 5; b0 = 7; op0 = 3'b010;
    wait_acc(0);
    v0 = 0;
    drain();

    // Both held valid: ADD 1+1 vs SUB 3-3, grants must alternate
    v0 = 1; a0 = 1; b0 = 1; op0 = 3'b010;
    v1 = 1; a1 = 3; b1 = 3; op1 = 3'b100;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      do begin
        tick();
        n++;
      end while (!(acc0 || acc1) && n < 60);
      if (n >= 60) tmo_cnt++;
    end
    v0 = 0; v1 = 0;
    drain();

    // MUL 6*7 from requester 1
    v1 = 1; a1 = 6; b1 = 7; op1 = 3'b101;
    wait_acc(1);
    v1 = 0;
    drain();

    // Illegal op from requester 0
    v0 = 1; a0 = 9; b0 = 9; op0 = 3'b011;
    wait_acc(0);
    v0 = 0;
    drain();

    // Response stalled while requester 1 waits
    rsp_rdy = 0;
    v0 = 1; a0 = 2; b0 = 2; op0 = 3'b010;
    wait_acc(0);
    v0 = 0;
    v1 = 1; a1 = 32'h0F0; b1 = 32'h00F; op1 = 3'b001;
    repeat (7) tick();
    rsp_rdy = 1;
    wait_acc(1);
    v1 = 0;
    drain();

    // Reset in the middle of a MUL
    v0 = 1; a0 = 3; b0 = 4; op0 = 3'b101;
    wait_acc(0);
    v0 = 0;
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    v0 = 1; a0 = 10; b0 = 20; op0 = 3'b110;
    v1 = 1; a1 = 1;  b1 = 2;  op1 = 3'b000;
    wait_acc(0);
    v0 = 0; v1 = 0;
    drain();

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      if (acc0 || (v0 && $urandom_range(0, 15) == 0)) v0 = 0;
      if (!v0 && $urandom_range(0, 2) == 0) begin
        v0 = 1; a0 = rnd(); b0 = rnd(); op0 = 3'($urandom_range(0, 7));
      end
      if (acc1 || (v1 && $urandom_range(0, 15) == 0)) v1 = 0;
      if (!v1 && $urandom_range(0, 2) == 0) begin
        v1 = 1; a1 = rnd(); b1 = rnd(); op1 = 3'($urandom_range(0, 7));
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    v0 = 0; v1 = 0; rsp_rdy = 1;
    drain();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
